// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types for the 4:1 mux round-robin arbiter.
// State encoding, source count, select width, one-hot helper.
package mux_rr_arbiter_pkg;

  localparam int N_SRC = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GRANT = 2'b01,
    ST_GAP   = 2'b10
  } state_e;

  function automatic logic [N_SRC-1:0] onehot(
    input logic [SEL_W-1:0] i
  );
    return N_SRC'(1) << i;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester/arbiter bundle: req, done in; sel, gnt, busy, timeout out.
// master = requester side, slave = arbiter side.
interface mux_rr_arbiter_if;
  import mux_rr_arbiter_pkg::*;

  logic [N_SRC-1:0] req;
  logic [N_SRC-1:0] done;
  logic [SEL_W-1:0] sel;
  logic [N_SRC-1:0] gnt;
  logic             busy;
  logic             timeout;

  modport master (
    output req,
    output done,
    input  sel,
    input  gnt,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output sel,
    output gnt,
    output busy,
    output timeout
  );

endinterface

// File: rtl/mux_rr_arbiter_rr_pick4.sv
// Combinational round-robin pick over 4 requesters.
// Ports: i_req, i_last in; o_idx (winner), o_any (any request) out.
module rr_pick4
  import mux_rr_arbiter_pkg::*;
(
  input  logic [N_SRC-1:0] i_req,
  input  logic [SEL_W-1:0] i_last,
  output logic [SEL_W-1:0] o_idx,
  output logic             o_any
);

  logic [SEL_W-1:0] w_j;
  logic             w_hit;

  // Scan starts just after the last owner and wraps.
  always_comb begin
    o_idx = '0;
    w_j   = '0;
    w_hit = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      w_j = i_last + SEL_W'(k + 1);
      if (!w_hit && i_req[w_j]) begin
        o_idx = w_j;
        w_hit = 1'b1;
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the 4:1 registered mux select.
// Ports: clk, rst_n, bus (slave: req/done in, sel/gnt/busy/timeout out).
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int HOLD_CYCLES = 8,
  parameter int CNT_W       = 4
)
(
  input logic             clk,
  input logic             rst_n,
  mux_rr_arbiter_if.slave bus
);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] r_last;
  logic [N_SRC-1:0] r_gnt;
  logic             r_busy;
  logic             r_timeout;

  logic [SEL_W-1:0] w_idx;
  logic             w_any;
  logic             w_own_done;
  logic             w_own_drop;
  logic             w_expire;
  logic             w_release;

  rr_pick4 u_pick (
    .i_req  (bus.req),
    .i_last (r_last),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  assign w_own_done = bus.done[r_sel];
  assign w_own_drop = ~bus.req[r_sel];
  assign w_expire   = (r_cnt == CNT_W'(HOLD_CYCLES - 1));
  assign w_release  = w_own_done | w_own_drop | w_expire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_sel     <= '0;
      r_last    <= SEL_W'(N_SRC - 1);
      r_gnt     <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state <= ST_GRANT;
            r_gnt   <= onehot(w_idx);
            r_sel   <= w_idx;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_GRANT: begin
          if (w_release) begin
            r_state   <= ST_GAP;
            r_gnt     <= '0;
            r_last    <= r_sel;
            // Expiry alone flags a revoke.
            r_timeout <= w_expire & ~w_own_done
                       & ~w_own_drop;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_GAP: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sel     = r_sel;
  assign bus.gnt     = r_gnt;
  assign bus.busy    = r_busy;
  assign bus.timeout = r_timeout;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter.
// Scenario tasks with inline checks and a pass/total summary.
module tb_mux_rr_arbiter;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  mux_rr_arbiter_if bus ();

  mux_rr_arbiter #(
    .HOLD_CYCLES (8),
    .CNT_W       (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.done = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    bus.req  = '0;
    bus.done = '0;
    repeat (4) step();
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.done = '0;
    step();
    n_chk++;
    if (bus.gnt !== 4'b0000)
      $display("FAIL rst_gnt got=%b exp=0000", bus.gnt);
    else n_pass++;
    n_chk++;
    if (bus.sel !== 2'd0)
      $display("FAIL rst_sel got=%0d exp=0", bus.sel);
    else n_pass++;
    n_chk++;
    if (bus.busy !== 1'b0)
      $display("FAIL rst_busy got=%b exp=0", bus.busy);
    else n_pass++;
    n_chk++;
    if (bus.timeout !== 1'b0)
      $display("FAIL rst_tmo got=%b exp=0", bus.timeout);
    else n_pass++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    bus.req = 4'b0100;
    step();
    n_chk++;
    if (bus.gnt !== 4'b0100)
      $display("FAIL single_gnt got=%b exp=0100", bus.gnt);
    else n_pass++;
    n_chk++;
    if (bus.sel !== 2'd2)
      $display("FAIL single_sel got=%0d exp=2", bus.sel);
    else n_pass++;
    n_chk++;
    if (bus.busy !== 1'b1)
      $display("FAIL single_busy got=%b exp=1", bus.busy);
    else n_pass++;
    drain();
  endtask

  task automatic test_round_robin();
    int          order[5] = '{0, 1, 2, 3, 0};
    logic [3:0]  exp;
    int          hold;
    do_reset();
    bus.req = 4'b1111;
    step();
    for (int i = 0; i < 5; i++) begin
      exp = 4'b0001 << order[i];
      n_chk++;
      if (bus.gnt !== exp)
        $display("FAIL rr_gnt%0d got=%b exp=%b",
                 i, bus.gnt, exp);
      else n_pass++;
      n_chk++;
      if (bus.sel !== 2'(order[i]))
        $display("FAIL rr_sel%0d got=%0d exp=%0d",
                 i, bus.sel, order[i]);
      else n_pass++;
      hold = 1;
      for (int c = 0; c < 20 && bus.gnt === exp; c++) begin
        step();
        if (bus.gnt === exp) hold++;
      end
      n_chk++;
      if (hold !== 8)
        $display("FAIL rr_hold%0d got=%0d exp=8", i, hold);
      else n_pass++;
      n_chk++;
      if (bus.gnt !== 4'b0000 || bus.timeout !== 1'b1)
        $display("FAIL rr_gap%0d got=%b/%b exp=0000/1",
                 i, bus.gnt, bus.timeout);
      else n_pass++;
      step();
      n_chk++;
      if (bus.gnt !== 4'b0000 || bus.timeout !== 1'b0
          || bus.busy !== 1'b0)
        $display("FAIL rr_idle%0d got=%b/%b/%b exp=0000/0/0",
                 i, bus.gnt, bus.timeout, bus.busy);
      else n_pass++;
      step();
    end
    drain();
  endtask

  task automatic test_done_early();
    do_reset();
    bus.req = 4'b0110;
    step();
    n_chk++;
    if (bus.gnt !== 4'b0010)
      $display("FAIL early_gnt got=%b exp=0010", bus.gnt);
    else n_pass++;
    bus.done = 4'b0100;
    step();
    bus.done = 4'b0000;
    n_chk++;
    if (bus.gnt !== 4'b0010)
      $display("FAIL early_nonown got=%b exp=0010", bus.gnt);
    else n_pass++;
    step();
    bus.done = 4'b0010;
    step();
    bus.done = 4'b0000;
    n_chk++;
    if (bus.gnt !== 4'b0000 || bus.timeout !== 1'b0)
      $display("FAIL early_rel got=%b/%b exp=0000/0",
               bus.gnt, bus.timeout);
    else n_pass++;
    step();
    step();
    n_chk++;
    if (bus.gnt !== 4'b0100)
      $display("FAIL early_next got=%b exp=0100", bus.gnt);
    else n_pass++;
    drain();
  endtask

  task automatic test_done_at_expiry();
    do_reset();
    bus.req = 4'b0001;
    step();
    repeat (7) step();
    n_chk++;
    if (bus.gnt !== 4'b0001)
      $display("FAIL exp_hold got=%b exp=0001", bus.gnt);
    else n_pass++;
    bus.done = 4'b0001;
    step();
    bus.done = 4'b0000;
    n_chk++;
    if (bus.gnt !== 4'b0000 || bus.timeout !== 1'b0)
      $display("FAIL exp_rel got=%b/%b exp=0000/0",
               bus.gnt, bus.timeout);
    else n_pass++;
    step();
    n_chk++;
    if (bus.gnt !== 4'b0000 || bus.timeout !== 1'b0)
      $display("FAIL exp_idle got=%b/%b exp=0000/0",
               bus.gnt, bus.timeout);
    else n_pass++;
    step();
    n_chk++;
    if (bus.gnt !== 4'b0001)
      $display("FAIL exp_regnt got=%b exp=0001", bus.gnt);
    else n_pass++;
    drain();
  endtask

  task automatic test_drop();
    do_reset();
    bus.req = 4'b0100;
    step();
    bus.req = 4'b1000;
    step();
    n_chk++;
    if (bus.gnt !== 4'b0000 || bus.timeout !== 1'b0)
      $display("FAIL drop_rel got=%b/%b exp=0000/0",
               bus.gnt, bus.timeout);
    else n_pass++;
    n_chk++;
    if (bus.sel !== 2'd2)
      $display("FAIL drop_sel got=%0d exp=2", bus.sel);
    else n_pass++;
    bus.req = 4'b1100;
    step();
    step();
    n_chk++;
    if (bus.gnt !== 4'b1000 || bus.sel !== 2'd3)
      $display("FAIL drop_last got=%b/%0d exp=1000/3",
               bus.gnt, bus.sel);
    else n_pass++;
    drain();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req = 4'b1000;
    step();
    step();
    n_chk++;
    if (bus.gnt !== 4'b1000)
      $display("FAIL mid_pre got=%b exp=1000", bus.gnt);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (bus.gnt !== 4'b0000 || bus.sel !== 2'd0
        || bus.busy !== 1'b0)
      $display("FAIL mid_async got=%b/%0d/%b exp=0000/0/0",
               bus.gnt, bus.sel, bus.busy);
    else n_pass++;
    bus.req = 4'b1001;
    #1;
    rst_n = 1'b1;
    step();
    n_chk++;
    if (bus.gnt !== 4'b0001 || bus.sel !== 2'd0)
      $display("FAIL mid_first got=%b/%0d exp=0001/0",
               bus.gnt, bus.sel);
    else n_pass++;
    drain();
  endtask

  initial begin
    n_chk    = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.done = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_done_early();
    test_done_at_expiry();
    test_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
